// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 64-byte lines into a 128-byte circular buffer
// and presents a 15-byte decode window with per-cycle consume and redirect flush.
module fetch_unit #(
    parameter int BUF_BYTES = 128,
    parameter int WIN_BYTES = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  entry,
    output logic                         reqcyc,
    input  logic                         reqack,
    output logic [63:0]                  req,
    output logic [12:0]                  reqtag,
    input  logic                         respcyc,
    output logic                         respack,
    input  logic [63:0]                  resp,
    input  logic                         redirect,
    input  logic [63:0]                  redirect_rip,
    output logic [8*WIN_BYTES-1:0]       win_bytes,
    output logic [63:0]                  win_rip,
    output logic [$clog2(BUF_BYTES):0]   win_avail,
    output logic                         win_valid,
    input  logic [3:0]                   consume,
    output logic [1:0]                   dbg_state
);

    localparam int PTR_W      = $clog2(BUF_BYTES);
    localparam int CNT_W      = PTR_W + 1;
    localparam int LINE_BYTES = 64;
    localparam logic [12:0] REQ_TAG = {1'b1, 4'b0001, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 reqcyc_q, reqcyc_d;
    logic [63:0]          req_q, req_d;
    logic [2:0]           beat_q, beat_d;
    logic [63:0]          fetch_rip_q, fetch_rip_d;
    logic [5:0]           skip_q, skip_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [63:0]          dec_rip_q, dec_rip_d;
    logic [8*BUF_BYTES-1:0] buf_q, buf_d;

    logic                 beat_wr;
    logic [2:0]           beat_idx;
    logic [5:0]           line_off;
    logic [5:0]           skip_gap;
    logic [3:0]           first_keep;
    logic [3:0]           kept;
    logic                 outstanding_d;

    // Handshakes: reqcyc is held with req/reqtag stable until the cycle reqack
    // is seen; response beats are always accepted, so respack mirrors respcyc.
    assign respack   = respcyc;
    assign reqcyc    = reqcyc_q;
    assign req       = req_q;
    assign reqtag    = REQ_TAG;
    assign win_rip   = dec_rip_q;
    assign win_avail = count_q;
    assign win_valid = (count_q >= CNT_W'(WIN_BYTES));
    assign dbg_state = state_q;

    // Only beats of a live line are stored; the redirect cycle drops its beat.
    assign beat_wr  = respcyc && !redirect && !reset &&
                      ((state_q == S_WAIT) || (state_q == S_ACTIVE));
    assign beat_idx = (state_q == S_WAIT) ? 3'd0 : beat_q;
    assign line_off = {beat_idx, 3'b000};
    assign skip_gap = skip_q - line_off;

    always_comb begin
        first_keep = 4'd0;
        if (skip_q > line_off) begin
            if (skip_gap >= 6'd8) begin
                first_keep = 4'd8;
            end else begin
                first_keep = 4'(skip_gap);
            end
        end
        kept = beat_wr ? (4'd8 - first_keep) : 4'd0;
    end

    // Kept bytes form a suffix of the beat and pack contiguously at wr_ptr.
    always_comb begin
        buf_d = buf_q;
        if (beat_wr) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) >= first_keep) begin
                    buf_d[{wr_ptr_q + PTR_W'(j) - PTR_W'(first_keep), 3'b000} +: 8] = resp[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        win_bytes = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            win_bytes[8*i +: 8] = buf_q[{rd_ptr_q + PTR_W'(i), 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        reqcyc_d    = reqcyc_q;
        req_d       = req_q;
        beat_d      = beat_q;
        fetch_rip_d = fetch_rip_q;
        skip_d      = skip_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        dec_rip_d   = dec_rip_q;

        case (state_q)
            S_IDLE: begin
                if (!reqcyc_q) begin
                    req_d = fetch_rip_q;
                    if ((count_q <= CNT_W'(LINE_BYTES)) && !redirect) begin
                        reqcyc_d = 1'b1;
                    end
                end else if (reqack) begin
                    reqcyc_d = 1'b0;
                    beat_d   = 3'd0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (respcyc) begin
                    beat_d  = 3'd1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (respcyc) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        fetch_rip_d = fetch_rip_q + 64'(LINE_BYTES);
                        skip_d      = 6'd0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // A cancelled request that was never acked still completes first.
                if (reqcyc_q) begin
                    if (reqack) begin
                        reqcyc_d = 1'b0;
                    end
                end else if (respcyc) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        outstanding_d = (state_d != S_IDLE) || reqcyc_d;

        if (redirect) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            dec_rip_d   = redirect_rip;
            fetch_rip_d = redirect_rip & ~64'h3f;
            skip_d      = redirect_rip[5:0];
            state_d     = outstanding_d ? S_DRAIN : S_IDLE;
        end else begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(kept);
            rd_ptr_d  = rd_ptr_q + PTR_W'(consume);
            count_d   = count_q + CNT_W'(kept) - CNT_W'(consume);
            dec_rip_d = dec_rip_q + 64'(consume);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            reqcyc_q    <= 1'b0;
            req_q       <= entry & ~64'h3f;
            beat_q      <= 3'd0;
            fetch_rip_q <= entry & ~64'h3f;
            skip_q      <= entry[5:0];
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dec_rip_q   <= entry;
        end else begin
            state_q     <= state_d;
            reqcyc_q    <= reqcyc_d;
            req_q       <= req_d;
            beat_q      <= beat_d;
            fetch_rip_q <= fetch_rip_d;
            skip_q      <= skip_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dec_rip_q   <= dec_rip_d;
        end
    end

    // Buffer contents are don't-care beyond count, so no reset is needed.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            assert (CNT_W'(consume) <= count_q)
            else $fatal(1, "consume %0d exceeds available %0d", consume, count_q);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a bus responder backed by an address-derived memory image
// and a byte-stream model (decode RIP plus contiguous valid-byte count).
module tb_fetch_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  entry;
    logic         reqcyc;
    logic         reqack;
    logic [63:0]  req;
    logic [12:0]  reqtag;
    logic         respcyc;
    logic         respack;
    logic [63:0]  resp;
    logic         redirect;
    logic [63:0]  redirect_rip;
    logic [119:0] win_bytes;
    logic [63:0]  win_rip;
    logic [7:0]   win_avail;
    logic         win_valid;
    logic [3:0]   consume;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
        .respcyc(respcyc), .respack(respack), .resp(resp),
        .redirect(redirect), .redirect_rip(redirect_rip),
        .win_bytes(win_bytes), .win_rip(win_rip), .win_avail(win_avail),
        .win_valid(win_valid), .consume(consume), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Model: bytes [m_rip, m_rip+m_count) are buffered, each equal to mem_byte(addr).
    logic [63:0] m_rip;
    int          m_count;
    int          prev_count;

    // Responder state for the single outstanding line.
    bit          r_open, r_live, r_acked;
    logic [63:0] r_addr;
    int          r_beats, r_ack_wait, r_gap;
    int          lines_done;
    logic [63:0] acked_q[$];

    // Stimulus policy.
    int          ack_min, ack_max, lat, lat_jit, gap_max, cons_lo, cons_hi;
    bit          want_redirect;
    logic [63:0] want_rip;
    bit          force_on_beat, force_redir, force_hit;
    logic [63:0] force_rip;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ (a[15:8] - 8'h10) ^ a[23:16] ^ a[31:24];
    endfunction

    task automatic tick_sample();
        logic [119:0] exp_w, mask;
        int n;
        @(negedge clk);
        checks++;
        if (win_avail !== 8'(m_count)) begin
            errors++; $display("FAIL win_avail: got %0d expected %0d", win_avail, m_count);
        end
        checks++;
        if (win_rip !== m_rip) begin
            errors++; $display("FAIL win_rip: got %h expected %h", win_rip, m_rip);
        end
        checks++;
        if (win_valid !== (m_count >= 15)) begin
            errors++; $display("FAIL win_valid: got %b with %0d bytes", win_valid, m_count);
        end
        exp_w = '0; mask = '0;
        n = (m_count < 15) ? m_count : 15;
        for (int i = 0; i < n; i++) begin
            exp_w[8*i +: 8] = mem_byte(m_rip + 64'(i));
            mask[8*i +: 8]  = 8'hff;
        end
        checks++;
        if ((win_bytes & mask) !== exp_w) begin
            errors++; $display("FAIL win_bytes: got %h expected %h (mask %h)", win_bytes & mask, exp_w, mask);
        end
        if (reqcyc === 1'b1) begin
            checks++;
            if (reqtag !== 13'h1100) begin
                errors++; $display("FAIL reqtag: got %h expected 1100", reqtag);
            end
            if (!r_open) begin
                checks++;
                if (prev_count > 64) begin
                    errors++; $display("FAIL req_gate: request raised with %0d bytes buffered, limit 64", prev_count);
                end
                checks++;
                if (req !== ((m_rip + 64'(m_count)) & ~64'h3f)) begin
                    errors++; $display("FAIL req_addr: got %h expected %h", req, (m_rip + 64'(m_count)) & ~64'h3f);
                end
                r_open = 1; r_live = 1; r_acked = 0; r_addr = req; r_beats = 0;
                r_ack_wait = $urandom_range(ack_min, ack_max);
            end else if (r_acked) begin
                checks++; errors++;
                $display("FAIL req_overlap: reqcyc high while line %h still outstanding, expected low", r_addr);
            end else begin
                checks++;
                if (req !== r_addr) begin
                    errors++; $display("FAIL req_stable: got %h expected %h", req, r_addr);
                end
            end
        end else if (r_open && !r_acked) begin
            checks++; errors++;
            $display("FAIL req_hold: reqcyc got 0 before ack, expected 1");
        end
    endtask

    task automatic tick_drive();
        int c;
        logic [63:0] endp;
        reqack = 0; respcyc = 0; resp = '0; redirect = 0; consume = '0;
        if (r_open && !r_acked && reqcyc) begin
            if (r_ack_wait == 0) reqack = 1;
            else r_ack_wait--;
        end
        if (r_open && r_acked && r_beats < 8) begin
            if (r_gap == 0) begin
                respcyc = 1;
                for (int j = 0; j < 8; j++)
                    resp[8*j +: 8] = mem_byte(r_addr + 64'(8 * r_beats + j));
                r_gap = $urandom_range(0, gap_max);
            end else begin
                r_gap--;
            end
        end
        c = $urandom_range(cons_lo, cons_hi);
        if (c > m_count) c = m_count;
        consume = 4'(c);
        if (force_on_beat && respcyc && m_count == 15) begin
            consume = 4'd15;
            if (force_redir) begin
                redirect = 1; redirect_rip = force_rip;
            end
            force_on_beat = 0; force_hit = 1;
        end
        if (want_redirect) begin
            redirect = 1; redirect_rip = want_rip; want_redirect = 0;
        end
        prev_count = m_count;
        endp = m_rip + 64'(m_count);
        if (redirect) begin
            m_rip = redirect_rip; m_count = 0;
            if (r_open) r_live = 0;
        end else begin
            if (respcyc && r_live)
                for (int j = 0; j < 8; j++)
                    if (r_addr + 64'(8 * r_beats + j) >= endp) m_count++;
            m_rip = m_rip + 64'(consume);
            m_count = m_count - int'(consume);
        end
        if (respcyc) begin
            r_beats++;
            if (r_beats == 8) begin
                r_open = 0; r_acked = 0; lines_done++;
            end
        end
        if (reqack) begin
            r_acked = 1; r_gap = lat + $urandom_range(0, lat_jit);
            acked_q.push_back(r_addr);
        end
    endtask

    task automatic tick();
        tick_sample();
        tick_drive();
    endtask

    task automatic wait_lines(input int n, input int budget);
        int target;
        int k;
        target = lines_done + n;
        k = 0;
        while (lines_done < target && k < budget) begin
            tick(); k++;
        end
        if (lines_done < target) begin
            checks++; errors++;
            $display("FAIL line_timeout: got %0d lines expected %0d", lines_done, target);
        end
    endtask

    task automatic set_policy(input int amin, input int amax, input int l, input int lj,
                              input int g, input int clo, input int chi);
        ack_min = amin; ack_max = amax; lat = l; lat_jit = lj; gap_max = g;
        cons_lo = clo; cons_hi = chi;
    endtask

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset = 1; entry = e;
        reqack = 0; respcyc = 0; resp = '0; redirect = 0; consume = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        m_rip = e; m_count = 0; prev_count = 0;
        r_open = 0; r_live = 0; r_acked = 0; r_beats = 0;
        acked_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; entry = 64'h1000;
        reqack = 0; respcyc = 0; resp = '0; redirect = 0; redirect_rip = '0; consume = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (reqcyc !== 1'b0) begin errors++; $display("FAIL rst_reqcyc: got %b expected 0", reqcyc); end
        checks++; if (req !== 64'h1000) begin errors++; $display("FAIL rst_req: got %h expected 1000", req); end
        checks++; if (reqtag !== 13'h1100) begin errors++; $display("FAIL rst_reqtag: got %h expected 1100", reqtag); end
        checks++; if (win_avail !== 8'd0) begin errors++; $display("FAIL rst_avail: got %0d expected 0", win_avail); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", win_valid); end
        checks++; if (win_rip !== 64'h1000) begin errors++; $display("FAIL rst_rip: got %h expected 1000", win_rip); end
        reset = 0;
        m_rip = 64'h1000; m_count = 0; prev_count = 0;
        r_open = 0; r_live = 0; r_acked = 0; r_beats = 0;
        acked_q.delete();
    endtask

    task automatic test_reset_fetch();
        set_policy(1, 3, 0, 0, 0, 0, 0);
        tick_sample();
        checks++; if (reqcyc !== 1'b1) begin errors++; $display("FAIL first_req: reqcyc got %b expected 1", reqcyc); end
        tick_drive();
        wait_lines(1, 100);
        tick_sample();
        checks++; if (win_avail !== 8'd64) begin errors++; $display("FAIL fetch_avail: got %0d expected 64", win_avail); end
        checks++; if (win_bytes[7:0] !== 8'h00) begin errors++; $display("FAIL fetch_byte0: got %h expected 00", win_bytes[7:0]); end
        checks++; if (win_bytes[119:112] !== 8'h0e) begin errors++; $display("FAIL fetch_byte14: got %h expected 0e", win_bytes[119:112]); end
        tick_drive();
    endtask

    task automatic test_misaligned();
        do_reset(64'h1013);
        set_policy(0, 2, 0, 1, 1, 0, 0);
        wait_lines(1, 100);
        tick_sample();
        checks++; if (win_avail !== 8'd45) begin errors++; $display("FAIL mis_avail: got %0d expected 45", win_avail); end
        checks++; if (win_rip !== 64'h1013) begin errors++; $display("FAIL mis_rip: got %h expected 1013", win_rip); end
        checks++; if (win_bytes[7:0] !== 8'h13) begin errors++; $display("FAIL mis_byte0: got %h expected 13", win_bytes[7:0]); end
        checks++;
        if (acked_q.size() < 1 || acked_q[0] !== 64'h1000) begin
            errors++; $display("FAIL mis_req: got %0d requests expected first at 1000", acked_q.size());
        end
        tick_drive();
    endtask

    task automatic test_streaming();
        do_reset(64'h1000);
        set_policy(0, 2, 1, 0, 0, 4, 4);
        for (int k = 0; k < 400; k++) tick();
        checks++;
        if (acked_q.size() < 3 || acked_q[1] !== 64'h1040) begin
            errors++; $display("FAIL stream_req2: got %0d requests expected second at 1040", acked_q.size());
        end
    endtask

    task automatic test_redirect_mid();
        int k;
        do_reset(64'h1000);
        set_policy(0, 0, 0, 0, 0, 0, 0);
        k = 0;
        while (!(r_open && r_acked && r_beats == 4) && k < 100) begin tick(); k++; end
        checks++;
        if (!(r_open && r_beats == 4)) begin errors++; $display("FAIL mid_setup: got %0d beats expected 4", r_beats); end
        want_redirect = 1; want_rip = 64'h2008;
        tick();
        tick_sample();
        checks++; if (win_avail !== 8'd0) begin errors++; $display("FAIL mid_flush: got %0d expected 0", win_avail); end
        tick_drive();
        wait_lines(2, 200);
        tick_sample();
        checks++; if (win_avail !== 8'd56) begin errors++; $display("FAIL mid_avail: got %0d expected 56", win_avail); end
        checks++;
        if (acked_q.size() != 2 || acked_q[1] !== 64'h2000) begin
            errors++; $display("FAIL mid_req: got %0d requests expected 2 ending at 2000", acked_q.size());
        end
        tick_drive();
    endtask

    task automatic test_redirect_before_ack();
        do_reset(64'h1000);
        set_policy(6, 6, 0, 0, 0, 0, 0);
        want_redirect = 1; want_rip = 64'h3045;
        tick();
        set_policy(0, 1, 0, 0, 0, 0, 0);
        wait_lines(2, 200);
        tick_sample();
        checks++; if (win_avail !== 8'd59) begin errors++; $display("FAIL pre_avail: got %0d expected 59", win_avail); end
        checks++; if (win_rip !== 64'h3045) begin errors++; $display("FAIL pre_rip: got %h expected 3045", win_rip); end
        checks++;
        if (acked_q.size() != 2 || acked_q[0] !== 64'h1000 || acked_q[1] !== 64'h3040) begin
            errors++; $display("FAIL pre_req: got %0d requests expected 1000 then 3040", acked_q.size());
        end
        tick_drive();
    endtask

    task automatic test_simultaneous(input bit with_redirect);
        int k;
        do_reset(64'h1031);
        set_policy(0, 2, 0, 0, 0, 0, 0);
        wait_lines(1, 100);
        tick_sample();
        checks++; if (win_avail !== 8'd15) begin errors++; $display("FAIL sim_setup: got %0d expected 15", win_avail); end
        tick_drive();
        force_on_beat = 1; force_redir = with_redirect; force_rip = 64'h4000; force_hit = 0;
        k = 0;
        while (!force_hit && k < 100) begin tick(); k++; end
        force_on_beat = 0;
        tick_sample();
        checks++;
        if (!force_hit) begin
            errors++; $display("FAIL sim_timeout: got no beat at 15 bytes, expected one");
        end else if (win_avail !== (with_redirect ? 8'd0 : 8'd8)) begin
            errors++; $display("FAIL sim_count: got %0d expected %0d", win_avail, with_redirect ? 0 : 8);
        end
        tick_drive();
    endtask

    task automatic test_random();
        do_reset(64'h1000 + 64'($urandom_range(0, 255)));
        set_policy(0, 3, 0, 2, 2, 0, 15);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                want_redirect = 1;
                want_rip = 64'($urandom_range(16'h1000, 16'hffff));
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; entry = '0; reqack = 0; respcyc = 0; resp = '0;
        redirect = 0; redirect_rip = '0; consume = '0;
        want_redirect = 0; want_rip = '0;
        force_on_beat = 0; force_redir = 0; force_hit = 0; force_rip = '0;
        lines_done = 0;
        set_policy(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_reset_fetch();
        test_misaligned();
        test_streaming();
        test_redirect_mid();
        test_redirect_before_ack();
        test_simultaneous(1'b0);
        test_simultaneous(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
